// File: rtl/clk_gate_ctrl.sv
// Idle-driven enable controller for an integrated clock-gating cell.
// Drops the gate enable after a programmable quiet period and re-enables it on demand.
module clk_gate_ctrl #(
   parameter int THRESH_W    = 8,
   parameter int WAKE_CYCLES = 2,
   parameter int EVT_W       = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                busy_i,
   input  logic                force_on_i,
   input  logic [THRESH_W-1:0] idle_thresh_i,
   output logic                en_o,
   output logic                ack_o,
   output logic                gated_o,
   output logic [EVT_W-1:0]    gate_evts_o
);

   localparam int WAKE_W = $clog2(WAKE_CYCLES) + 1;
   localparam int CNT_W  = (THRESH_W > WAKE_W) ? THRESH_W : WAKE_W;
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ACTIVE,
      GATED,
      WAKE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] thresh_ext;
   logic             quiet;
   logic             wake_src;
   logic             evt_inc;

   assign thresh_ext = CNT_W'(idle_thresh_i);
   assign wake_src   = req_i | busy_i | force_on_i;
   assign quiet      = ~wake_src;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      evt_inc   = 1'b0;
      case (state)
         ACTIVE: begin
            // Equality compare is safe: any activity clears cnt, so a lowered threshold just recounts.
            if (!quiet || thresh_ext == '0) begin
               cnt_nxt = '0;
            end else if (cnt == thresh_ext - CNT_W'(1)) begin
               state_nxt = GATED;
               cnt_nxt   = '0;
               evt_inc   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         GATED: begin
            if (wake_src) begin
               state_nxt = WAKE;
               cnt_nxt   = '0;
            end
         end
         WAKE: begin
            if (cnt == WAKE_LAST) begin
               state_nxt = ACTIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ACTIVE;
         cnt         <= '0;
         en_o        <= 1'b1;
         ack_o       <= 1'b1;
         gated_o     <= 1'b0;
         gate_evts_o <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         en_o    <= (state_nxt != GATED);
         ack_o   <= (state_nxt == ACTIVE);
         gated_o <= (state_nxt == GATED);
         if (evt_inc && gate_evts_o != '1) begin
            gate_evts_o <= gate_evts_o + EVT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: a table of per-cycle vectors plus
// hand-written sequences for reset-in-wake, long idle, and counter saturation.
module tb_clk_gate_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       req_i;
   logic       busy_i;
   logic       force_on_i;
   logic [7:0] idle_thresh_i;
   logic       en_o;
   logic       ack_o;
   logic       gated_o;
   logic [3:0] gate_evts_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic       req;
      logic       busy;
      logic       frc;
      logic [7:0] thr;
      logic       en;
      logic       ack;
      logic       gated;
      logic [3:0] evts;
   } vec_t;

   vec_t vecs[$];

   clk_gate_ctrl #(
      .THRESH_W   (8),
      .WAKE_CYCLES(2),
      .EVT_W      (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .busy_i       (busy_i),
      .force_on_i   (force_on_i),
      .idle_thresh_i(idle_thresh_i),
      .en_o         (en_o),
      .ack_o        (ack_o),
      .gated_o      (gated_o),
      .gate_evts_o  (gate_evts_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic rst, input logic req, input logic busy,
                                input logic frc, input logic [7:0] thr);
      rst_i         = rst;
      req_i         = req;
      busy_i        = busy;
      force_on_i    = frc;
      idle_thresh_i = thr;
   endtask

   task automatic checkOutput(input string name, input logic e, input logic a,
                              input logic g, input logic [3:0] ev);
      total++;
      if ({en_o, ack_o, gated_o, gate_evts_o} !== {e, a, g, ev}) begin
         bad++;
         $display("[TB] FAIL %s: got en=%b ack=%b gated=%b evts=%0d, want en=%b ack=%b gated=%b evts=%0d",
                  name, en_o, ack_o, gated_o, gate_evts_o, e, a, g, ev);
      end
   endtask

   // Each cycle starts 1 time unit after the rising edge: check outputs, then drive inputs.
   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   function automatic void addRows(input int n, input logic rst, input logic req,
                                   input logic busy, input logic frc, input logic [7:0] thr,
                                   input logic en, input logic ack, input logic gated,
                                   input logic [3:0] evts);
      vec_t v;
      v.rst = rst; v.req = req; v.busy = busy; v.frc = frc; v.thr = thr;
      v.en = en; v.ack = ack; v.gated = gated; v.evts = evts;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   initial begin
      //      n  rst req bsy frc thr  en ack gtd evts
      addRows(4, 0,  0,  0,  0,  4,   1, 1,  0,  0);  // cycles 0-3 counting quiet
      addRows(6, 0,  0,  0,  0,  4,   0, 0,  1,  1);  // cycles 4-9 gated
      addRows(1, 0,  1,  0,  0,  4,   0, 0,  1,  1);  // cycle 10 req rises
      addRows(2, 0,  1,  0,  0,  4,   1, 0,  0,  1);  // cycles 11-12 wake
      addRows(1, 0,  1,  0,  0,  4,   1, 1,  0,  1);  // cycle 13 ack
      addRows(4, 0,  0,  0,  0,  4,   1, 1,  0,  1);  // 14-17 recount
      addRows(1, 0,  0,  1,  0,  4,   0, 0,  1,  2);  // 18 busy pulse while gated
      addRows(2, 0,  0,  0,  0,  4,   1, 0,  0,  2);  // 19-20 wake
      addRows(4, 0,  0,  0,  0,  4,   1, 1,  0,  2);  // 21-24 recount
      addRows(1, 0,  0,  0,  1,  4,   0, 0,  1,  3);  // 25 force while gated
      addRows(2, 0,  0,  0,  1,  4,   1, 0,  0,  3);  // 26-27 wake
      addRows(1, 0,  0,  0,  1,  4,   1, 1,  0,  3);  // 28 active
      addRows(2, 0,  0,  0,  0,  4,   1, 1,  0,  3);  // 29-30 cnt reaches 2
      addRows(4, 0,  0,  0,  0,  1,   1, 1,  0,  3);  // threshold lowered below cnt
      addRows(1, 0,  0,  1,  0,  1,   1, 1,  0,  3);  // activity clears cnt
      addRows(1, 0,  0,  0,  0,  1,   1, 1,  0,  3);  // one quiet cycle gates
      addRows(1, 0,  1,  0,  0,  1,   0, 0,  1,  4);
      addRows(2, 0,  1,  0,  0,  1,   1, 0,  0,  4);
      addRows(1, 0,  1,  0,  0,  4,   1, 1,  0,  4);

      applyStimulus(1, 0, 0, 0, 4);
      nextCycle();
      nextCycle();
      checkOutput("reset_state", 1, 1, 0, 0);

      foreach (vecs[i]) begin
         checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack, vecs[i].gated, vecs[i].evts);
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].busy, vecs[i].frc, vecs[i].thr);
         nextCycle();
      end

      // Threshold reached in the same cycle req rises: stays active, ack immediate.
      applyStimulus(0, 0, 0, 0, 4);
      repeat (3) nextCycle();
      applyStimulus(0, 1, 0, 0, 4);
      nextCycle();
      checkOutput("req_at_thresh", 1, 1, 0, 4);

      applyStimulus(0, 0, 0, 1, 4);
      for (int i = 0; i < 100; i++) begin
         nextCycle();
         checkOutput("force_hold", 1, 1, 0, 4);
      end

      // Gate again, wake by req, then reset two cycles into the wake.
      applyStimulus(0, 0, 0, 0, 4);
      repeat (4) nextCycle();
      checkOutput("gate_again", 0, 0, 1, 5);
      applyStimulus(0, 1, 0, 0, 4);
      nextCycle();
      checkOutput("wake_en", 1, 0, 0, 5);
      nextCycle();
      checkOutput("wake_no_ack", 1, 0, 0, 5);
      applyStimulus(1, 1, 0, 0, 4);
      nextCycle();
      checkOutput("rst_in_wake", 1, 1, 0, 0);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(0, 0, (i % 3) == 2, 0, 4);
         nextCycle();
         checkOutput("busy_every3", 1, 1, 0, 0);
      end

      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 1000; i++) begin
         nextCycle();
         checkOutput("thresh_zero", 1, 1, 0, 0);
      end

      for (int i = 1; i <= 20; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         nextCycle();
         checkOutput($sformatf("sat_gate%0d", i), 0, 0, 1, (i > 15) ? 4'd15 : 4'(i));
         applyStimulus(0, 0, 0, 1, 1);
         repeat (3) nextCycle();
         checkOutput($sformatf("sat_wake%0d", i), 1, 1, 0, (i > 15) ? 4'd15 : 4'(i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
